// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit, its write-register mux and the datapath.
package mc_pkg;

    localparam int unsigned SP_INIT = 227;

    typedef enum logic [4:0] {
        ST_RST_SP   = 5'd0,
        ST_FETCH    = 5'd1,
        ST_IR_LOAD  = 5'd2,
        ST_DECODE   = 5'd3,
        ST_EXEC_R   = 5'd4,
        ST_WB_R     = 5'd5,
        ST_ADDI_EX  = 5'd6,
        ST_ADDI_WB  = 5'd7,
        ST_MEM_ADDR = 5'd8,
        ST_LW_RD    = 5'd9,
        ST_LW_WB    = 5'd10,
        ST_SW_WR    = 5'd11,
        ST_BEQ      = 5'd12,
        ST_JUMP     = 5'd13,
        ST_JAL      = 5'd14,
        ST_EXC      = 5'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    typedef enum logic [1:0] {WR_RT = 2'b00, WR_RD = 2'b01, WR_RA = 2'b10, WR_SP = 2'b11} wr_sel_e;
    typedef enum logic [1:0] {WD_ALUOUT = 2'b00, WD_MDR = 2'b01, WD_PC = 2'b10, WD_SP_INIT = 2'b11} wd_sel_e;
    typedef enum logic [1:0] {ALUB_REG = 2'b00, ALUB_FOUR = 2'b01, ALUB_IMM = 2'b10, ALUB_IMM_SH2 = 2'b11} alu_b_e;
    typedef enum logic [2:0] {ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_PASS = 3'b111} alu_op_e;
    typedef enum logic [1:0] {PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10, PC_EXC = 2'b11} pc_src_e;

    typedef struct packed {
        logic    pc_wr;
        logic    pc_wr_cond;
        logic    iord;
        logic    mem_wr;
        logic    ir_wr;
        logic    reg_wr;
        wr_sel_e wr_sel;
        wd_sel_e wd_sel;
        logic    alu_src_a;
        alu_b_e  alu_src_b;
        alu_op_e alu_op;
        pc_src_e pc_src;
        logic    epc_wr;
    } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control-unit <-> datapath bundle: instruction fields and flags in, strobes and debug state out.
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    logic       pc_wr;
    logic       pc_wr_cond;
    logic       iord;
    logic       mem_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic [1:0] wr_sel;
    logic [1:0] wd_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       epc_wr;
    logic [4:0] state_o;

    modport master (
        input  opcode, funct, zero, overflow,
        output pc_wr, pc_wr_cond, iord, mem_wr, ir_wr, reg_wr, wr_sel, wd_sel,
               alu_src_a, alu_src_b, alu_op, pc_src, epc_wr, state_o
    );

    modport slave (
        output opcode, funct, zero, overflow,
        input  pc_wr, pc_wr_cond, iord, mem_wr, ir_wr, reg_wr, wr_sel, wd_sel,
               alu_src_a, alu_src_b, alu_op, pc_src, epc_wr, state_o
    );
endinterface

// File: rtl/mc_alu_dec.sv
// R-type funct decoder: ALU operation plus a flag marking supported funct codes.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output alu_op_e    alu_op,
    output logic       valid
);

    always_comb begin
        alu_op = ALU_ADD;
        valid  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset control unit: Moore FSM with registered strobes, $sp init after reset,
// and an exception path for bad opcode/funct or arithmetic overflow.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter logic [1:0] EXC_VEC_SEL = 2'b11
)(
    input  logic              clk,
    input  logic              reset_n,
    mc_control_fsm_if.master  bus
);

    state_e  state, state_nx;
    ctrl_t   ctrl;
    logic    armed;
    alu_op_e r_op;
    logic    r_valid;

    mc_alu_dec u_alu_dec (
        .funct  (bus.funct),
        .alu_op (r_op),
        .valid  (r_valid)
    );

    function automatic ctrl_t ctrl_for(input state_e s, input alu_op_e op);
        ctrl_t c;
        c = '0;
        case (s)
            ST_RST_SP:   begin c.reg_wr = 1'b1; c.wr_sel = WR_SP; c.wd_sel = WD_SP_INIT; end
            ST_FETCH:    begin c.alu_src_b = ALUB_FOUR; c.pc_wr = 1'b1; end
            ST_IR_LOAD:  c.ir_wr = 1'b1;
            ST_DECODE:   c.alu_src_b = ALUB_IMM_SH2;
            ST_EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_src_b = ALUB_REG; c.alu_op = op; end
            ST_WB_R:     begin c.reg_wr = 1'b1; c.wr_sel = WR_RD; c.wd_sel = WD_ALUOUT; end
            ST_ADDI_EX,
            ST_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = ALUB_IMM; end
            ST_ADDI_WB:  begin c.reg_wr = 1'b1; c.wr_sel = WR_RT; c.wd_sel = WD_ALUOUT; end
            ST_LW_RD:    c.iord = 1'b1;
            ST_LW_WB:    begin c.reg_wr = 1'b1; c.wr_sel = WR_RT; c.wd_sel = WD_MDR; end
            ST_SW_WR:    begin c.iord = 1'b1; c.mem_wr = 1'b1; end
            ST_BEQ:      begin
                c.alu_src_a = 1'b1; c.alu_src_b = ALUB_REG; c.alu_op = ALU_SUB;
                c.pc_wr_cond = 1'b1; c.pc_src = PC_ALUOUT;
            end
            ST_JUMP:     begin c.pc_wr = 1'b1; c.pc_src = PC_JUMP; end
            ST_JAL:      begin
                c.reg_wr = 1'b1; c.wr_sel = WR_RA; c.wd_sel = WD_PC;
                c.pc_wr = 1'b1; c.pc_src = PC_JUMP;
            end
            ST_EXC:      begin
                c.alu_src_b = ALUB_FOUR; c.alu_op = ALU_SUB; c.epc_wr = 1'b1;
                c.pc_wr = 1'b1; c.pc_src = pc_src_e'(EXC_VEC_SEL);
            end
            default:     c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_nx = ST_FETCH;
        case (state)
            ST_RST_SP:   state_nx = armed ? ST_FETCH : ST_RST_SP;
            ST_FETCH:    state_nx = ST_IR_LOAD;
            ST_IR_LOAD:  state_nx = ST_DECODE;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_nx = ST_EXEC_R;
                    OP_ADDI:      state_nx = ST_ADDI_EX;
                    OP_LW, OP_SW: state_nx = ST_MEM_ADDR;
                    OP_BEQ:       state_nx = ST_BEQ;
                    OP_J:         state_nx = ST_JUMP;
                    OP_JAL:       state_nx = ST_JAL;
                    default:      state_nx = ST_EXC;
                endcase
            end
            // Overflow only matters for add/sub; an unsupported funct faults regardless.
            ST_EXEC_R: begin
                if (!r_valid || (bus.overflow && r_op != ALU_AND)) state_nx = ST_EXC;
                else                                               state_nx = ST_WB_R;
            end
            ST_ADDI_EX:  state_nx = bus.overflow ? ST_EXC : ST_ADDI_WB;
            ST_MEM_ADDR: state_nx = (bus.opcode == OP_LW) ? ST_LW_RD : ST_SW_WR;
            ST_LW_RD:    state_nx = ST_LW_WB;
            default:     state_nx = ST_FETCH;
        endcase
    end

    // Strobes are registered from the next state so they line up with state_o. The first edge
    // after reset release holds RST_SP and turns its strobes on, giving one visible $sp-write cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RST_SP;
            ctrl  <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_nx;
            ctrl  <= ctrl_for(state_nx, r_op);
            armed <= 1'b1;
        end
    end

    assign bus.pc_wr      = ctrl.pc_wr | (ctrl.pc_wr_cond & bus.zero);
    assign bus.pc_wr_cond = ctrl.pc_wr_cond;
    assign bus.iord       = ctrl.iord;
    assign bus.mem_wr     = ctrl.mem_wr;
    assign bus.ir_wr      = ctrl.ir_wr;
    assign bus.reg_wr     = ctrl.reg_wr;
    assign bus.wr_sel     = ctrl.wr_sel;
    assign bus.wd_sel     = ctrl.wd_sel;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.epc_wr     = ctrl.epc_wr;
    assign bus.state_o    = state;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle MIPS-subset control unit, one stage upstream of the write-register mux; drives its 2-bit selector (`wr_sel`) plus all other datapath strobes.
- Moore FSM sequences fetch, decode, execute, memory and writeback.
- After reset it initialises $sp (reg 29) before the first fetch.
- Handles invalid opcode/funct and arithmetic overflow by jumping to an exception vector.

Parameters:
- SP_INIT, 227, value written to reg 29 in the post-reset cycle.
- EXC_VEC_SEL, 2'b11, `pc_src` code that selects the exception vector.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- overflow  in  1  ALU signed-overflow flag, same cycle as EXEC states
- pc_wr  out  1  unconditional PC load
- pc_wr_cond  out  1  PC load if `zero`; gated inside this block into `pc_wr`
- iord  out  1  memory address: 0=PC, 1=ALUOut
- mem_wr  out  1  memory write strobe
- ir_wr  out  1  instruction register load
- reg_wr  out  1  register file write enable
- wr_sel  out  2  write-reg mux: 00=rt, 01=rd, 10=31, 11=29
- wd_sel  out  2  write data: 00=ALUOut, 01=MDR, 10=PC, 11=SP_INIT
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  3  000=add, 001=sub, 010=and, 111=pass
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=exception vector
- epc_wr  out  1  EPC load (PC-4 via ALU)
- state_o  out  5  current state, for debug and bench use

Behaviour:
- All outputs are a pure function of state, except `pc_wr`, which also ORs in `pc_wr_cond & zero`.
- Async reset: state = RST_SP; all strobes are 0 while `reset_n` is low.
- Reset mid-instruction aborts immediately, with no partial write.
- States and their asserted strobes:
  - RST_SP: `reg_wr`=1, `wr_sel`=11, `wd_sel`=11. Goes to FETCH.
  - FETCH: `iord`=0, `alu_src_a`=0, `alu_src_b`=01, add, `pc_src`=00, `pc_wr`=1 (PC <= PC+4). Goes to IR_LOAD.
  - IR_LOAD: `ir_wr`=1. Goes to DECODE.
  - DECODE: `alu_src_a`=0, `alu_src_b`=11, add (branch target into ALUOut). Next state by opcode:
    - 0x00 → EXEC_R
    - 0x08 → ADDI_EX
    - 0x23 / 0x2B → MEM_ADDR
    - 0x04 → BEQ
    - 0x02 → JUMP
    - 0x03 → JAL
    - otherwise → EXC
  - EXEC_R: `alu_src_a`=1, `alu_src_b`=00.
    - `alu_op` from funct: 0x20 add, 0x22 sub, 0x24 and.
    - Unknown funct → EXC.
    - Overflow on add/sub → EXC.
    - Otherwise → WB_R.
  - WB_R: `reg_wr`=1, `wr_sel`=01, `wd_sel`=00. Goes to FETCH.
  - ADDI_EX: `alu_src_a`=1, `alu_src_b`=10, add. Overflow → EXC, else → ADDI_WB.
  - ADDI_WB: `reg_wr`=1, `wr_sel`=00, `wd_sel`=00. Goes to FETCH.
  - MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, add. lw → LW_RD, sw → SW_WR.
  - LW_RD: `iord`=1 (memory read, 1-cycle latency). Goes to LW_WB.
  - LW_WB: `reg_wr`=1, `wr_sel`=00, `wd_sel`=01. Goes to FETCH.
  - SW_WR: `iord`=1, `mem_wr`=1. Goes to FETCH.
  - BEQ: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_wr_cond`=1, `pc_src`=01. Goes to FETCH.
  - JUMP: `pc_wr`=1, `pc_src`=10. Goes to FETCH.
  - JAL: `reg_wr`=1, `wr_sel`=10, `wd_sel`=10, `pc_wr`=1, `pc_src`=10. Goes to FETCH.
    - Register write uses the pre-update PC (already PC+4).
  - EXC: `alu_src_a`=0, `alu_src_b`=01, sub, `epc_wr`=1, `pc_wr`=1, `pc_src`=EXC_VEC_SEL. Goes to FETCH.
- Exceptions suppress `reg_wr` and `mem_wr` for the faulting instruction.
- Overflow is sampled only in EXEC_R (add/sub) and ADDI_EX; it is ignored for `and` and in all other states.
- Cycle counts:
  - R/addi/lw: 5/5/6
  - sw: 5
  - beq/j/jal: 4
  - exception adds 1 after the detecting state.
- State encoding is 5 bits; unused codes go to FETCH on the next edge.

Decomposition:
- Shared package/header (`mc_pkg`):
  - state codes
  - opcode/funct constants
  - `wr_sel`/`wd_sel`/`alu_op`/`pc_src` encodings, reused by the mux and datapath.
- One sub-module is natural: `mc_alu_dec` (combinational funct → `alu_op` + valid flag).

Test Plan:
- Release `reset_n` → first cycle RST_SP: `reg_wr`=1, `wr_sel`=11, `wd_sel`=11; next cycle FETCH with `pc_wr`=1.
- opcode=0x00, funct=0x20, overflow=0 → FETCH, IR_LOAD, DECODE, EXEC_R, WB_R; WB_R has `wr_sel`=01, `reg_wr`=1.
- opcode=0x23 → 6-cycle sequence; LW_WB has `wr_sel`=00, `wd_sel`=01; `mem_wr` never asserted.
- opcode=0x04 with zero=1 → `pc_wr`=1 in BEQ; with zero=0 → `pc_wr`=0, `pc_wr_cond`=1.
- opcode=0x03 → JAL asserts `wr_sel`=10, `wd_sel`=10, `pc_wr`=1, `pc_src`=10 in the same cycle.
- Exceptions and reset:
  - opcode=0x3F → EXC after DECODE.
  - funct=0x22 with overflow=1 in EXEC_R → EXC with `reg_wr` never 1.
  - `reset_n` pulsed low during LW_RD → state_o=RST_SP immediately, all strobes 0.
